// File: rtl/sa_mul_seq.sv
// sa_mul_seq: sequential unsigned shift-and-add multiplier.
// One shared WIDTH-bit adder built from 4-bit carry-lookahead slices is
// reused over up to WIDTH add/shift steps to form a 2*WIDTH-bit product.
// Optional feature macro: MUL_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits are all zero.

// 4-bit carry-lookahead adder slice.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Generate/propagate terms and flat lookahead carries (no ripple inside the slice).
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c;
    end
endmodule

module sa_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 op_done,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int NS = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [NS:0]      carry;
    logic             last_step;

`ifdef MUL_EARLY_TERM_EN
    logic [WIDTH-1:0] mq;
    logic             skip;
    logic [CW-1:0]    rem;

    // Remaining multiplier bits all zero: the rest of the run would only shift.
    assign skip      = (mq == '0);
    assign rem       = CW'(WIDTH) - cnt;
    // mq reaches zero after at most WIDTH steps, so this always terminates.
    assign last_step = skip;
`else
    assign last_step = (cnt == CW'(WIDTH - 1));
`endif

    // Shared adder: acc + (q_reg[0] ? m_reg : 0), carry-in 0, slices cascaded.
    assign addend   = q_reg[0] ? m_reg : '0;
    assign carry[0] = 1'b0;

    for (genvar s = 0; s < NS; s++) begin : g_cla
        cla4 u_cla (
            .a    (acc[4*s +: 4]),
            .b    (addend[4*s +: 4]),
            .cin  (carry[s]),
            .sum  (sum[4*s +: 4]),
            .cout (carry[s+1])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; clear wins over everything, start only counts in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_start) state_nxt = EXEC;
            EXEC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (op_clear) state_nxt = IDLE;
    end

    // Datapath: operand capture, add/shift steps, abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg <= '0;
            acc   <= '0;
            q_reg <= '0;
            cnt   <= '0;
`ifdef MUL_EARLY_TERM_EN
            mq    <= '0;
`endif
        end else if (op_clear) begin
            acc   <= '0;
            q_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (op_start) begin
                    m_reg <= multiplicand;
                    q_reg <= multiplier;
                    acc   <= '0;
                    cnt   <= '0;
`ifdef MUL_EARLY_TERM_EN
                    mq    <= multiplier;
`endif
                end
                EXEC: begin
`ifdef MUL_EARLY_TERM_EN
                    if (skip) begin
                        {acc, q_reg} <= {acc, q_reg} >> rem;
                    end else begin
                        {acc, q_reg} <= {carry[NS], sum, q_reg[WIDTH-1:1]};
                        mq           <= mq >> 1;
                        cnt          <= cnt + CW'(1);
                    end
`else
                    // Carry becomes the new acc MSB, so the product never overflows.
                    {acc, q_reg} <= {carry[NS], sum, q_reg[WIDTH-1:1]};
                    cnt          <= cnt + CW'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign result  = {acc, q_reg};
    assign op_done = (state == DONE);
    assign busy    = (state != IDLE);
endmodule
